// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B4 arbiter sharing one slave among NUM_MASTERS masters; grant held for CYC.
// Optional watchdog: define PERIPHERAL_ARB_TIMEOUT_EN to force ERR after TIMEOUT stalled cycles.
module peripheral_arbiter_wb #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]  wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]  wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]     wbm_we_i,
    input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]   wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]   wbm_bte_i,
    output logic [DW-1:0]              wbm_dat_o,
    output logic [NUM_MASTERS-1:0]     wbm_ack_o,
    output logic [NUM_MASTERS-1:0]     wbm_err_o,
    output logic [NUM_MASTERS-1:0]     wbm_rty_o,
    output logic [AW-1:0]              wbs_adr_o,
    output logic [DW-1:0]              wbs_dat_o,
    output logic [DW/8-1:0]            wbs_sel_o,
    output logic                       wbs_we_o,
    output logic                       wbs_cyc_o,
    output logic                       wbs_stb_o,
    output logic [2:0]                 wbs_cti_o,
    output logic [1:0]                 wbs_bte_o,
    input  logic [DW-1:0]              wbs_dat_i,
    input  logic                       wbs_ack_i,
    input  logic                       wbs_err_i,
    input  logic                       wbs_rty_i,
    output logic [NUM_MASTERS-1:0]     grant_o
);
    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned SW = DW / 8;
    localparam logic [NUM_MASTERS-1:0] OneBit = NUM_MASTERS'(1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_last;

    logic [IW-1:0] w_pick;
    int unsigned   w_best;
    logic          w_busy;
    logic          w_timeout;

    // Closest requester after the last grant, measured as rotational distance.
    always_comb begin
        w_pick = r_last;
        w_best = NUM_MASTERS;
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            if (wbm_cyc_i[j] && ((j + NUM_MASTERS - 1 - r_last) % NUM_MASTERS) < w_best) begin
                w_best = (j + NUM_MASTERS - 1 - r_last) % NUM_MASTERS;
                w_pick = IW'(j);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|wbm_cyc_i) begin
                        r_state <= StBusy;
                        r_grant <= OneBit << w_pick;
                        r_last  <= w_pick;
                    end
                end
                StBusy: begin
                    if (!wbm_cyc_i[r_last]) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_busy  = (r_state == StBusy);
    assign grant_o = r_grant;

`ifdef PERIPHERAL_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        w_resp;

    assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_timeout = w_busy && (r_wdog == 16'(TIMEOUT));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !w_busy || !wbm_cyc_i[r_last] || w_resp || w_timeout) begin
            r_wdog <= '0;
        end else if (wbm_stb_i[r_last]) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (w_busy) begin
            wbs_adr_o = wbm_adr_i[r_last*AW +: AW];
            wbs_dat_o = wbm_dat_i[r_last*DW +: DW];
            wbs_sel_o = wbm_sel_i[r_last*SW +: SW];
            wbs_we_o  = wbm_we_i[r_last];
            wbs_cyc_o = wbm_cyc_i[r_last];
            wbs_stb_o = wbm_stb_i[r_last] & ~w_timeout;
            wbs_cti_o = wbm_cti_i[r_last*3 +: 3];
            wbs_bte_o = wbm_bte_i[r_last*2 +: 2];
        end
    end

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = r_grant & {NUM_MASTERS{wbs_err_i | w_timeout}};
    assign wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i}};

endmodule
